// File: rtl/gpu_vram_pkg.sv
// gpu_vram_pkg: shared types for the video RAM arbiter.
//   op_e        - port slot tag carried down the read-return pipeline
//   wr_entry_t  - posted-write entry at default widths (addr, wdata, be)
package gpu_vram_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 64;

  typedef enum logic [1:0] {
    OP_IDLE    = 2'd0,
    OP_DISP_RD = 2'd1,
    OP_CPU_WR  = 2'd2,
    OP_CPU_RD  = 2'd3
  } op_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]   addr;
    logic [DEF_DATA_W-1:0]   wdata;
    logic [DEF_DATA_W/8-1:0] be;
  } wr_entry_t;

  function automatic logic is_rd(input op_e op);
    return (op == OP_DISP_RD) || (op == OP_CPU_RD);
  endfunction

endpackage

// File: rtl/gpu_vram_wfifo.sv
// gpu_vram_wfifo: synchronous FIFO holding posted CPU writes.
//   i_clock, i_reset     - clock, sync active-high reset (flushes contents)
//   i_push, i_wdata      - enqueue; ignored while full
//   i_pop,  o_rdata      - dequeue; o_rdata is the current head (show-ahead)
//   o_full, o_empty      - status
//   o_count              - entries held, 0..DEPTH
import gpu_vram_pkg::*;

module gpu_vram_wfifo #(
  parameter type entry_t = wr_entry_t,
  parameter int  DEPTH   = 4
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  entry_t                   i_wdata,
  input  logic                     i_pop,
  output entry_t                   o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_count;
  logic            w_push, w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage carries no reset; only pointers/count define validity.
  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/gpu_vram_arbiter.sv
// gpu_vram_arbiter: shares one single-port 64-bit video RAM between the
// display fetch path (absolute priority, fixed 2-edge read latency) and the
// CPU bus (writes posted through a FIFO, reads only once the FIFO is empty).
//   clock, reset                      - clock, sync active-high reset
//   disp_req/disp_addr                - display fetch request
//   disp_valid/disp_data              - display return (1-cycle pulse)
//   cpu_req_*                         - CPU valid/ready request channel
//   cpu_rd_valid/cpu_rd_data          - CPU read return (1-cycle pulse)
//   fifo_count                        - posted writes pending
//   mem_en/we/addr/wdata/be, mem_rdata - registered RAM port
import gpu_vram_pkg::*;

module gpu_vram_arbiter #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     disp_req,
  input  logic [ADDR_W-1:0]        disp_addr,
  output logic                     disp_valid,
  output logic [DATA_W-1:0]        disp_data,
  input  logic                     cpu_req_valid,
  input  logic                     cpu_req_we,
  input  logic [ADDR_W-1:0]        cpu_req_addr,
  input  logic [DATA_W-1:0]        cpu_req_wdata,
  input  logic [DATA_W/8-1:0]      cpu_req_be,
  output logic                     cpu_req_ready,
  output logic                     cpu_rd_valid,
  output logic [DATA_W-1:0]        cpu_rd_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [DATA_W/8-1:0]      mem_be,
  input  logic [DATA_W-1:0]        mem_rdata
);

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] be;
  } wr_t;

  wr_t   w_push_ent, w_head;
  logic  w_full, w_empty, w_push, w_pop;
  op_e   w_sel;

  op_e                 r_s1, r_s2;
  logic                r_mem_en, r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W/8-1:0] r_mem_be;
  logic                r_disp_valid, r_cpu_rd_valid;
  logic [DATA_W-1:0]   r_disp_data, r_cpu_rd_data;

  // Reads wait for an empty FIFO (read-after-write ordering) and lose to the
  // display outright, so ready for a read equals "CPU_RD wins this edge".
  assign cpu_req_ready = !reset && (cpu_req_we ? !w_full : (w_empty && !disp_req));

  assign w_push     = cpu_req_valid && cpu_req_we && cpu_req_ready;
  assign w_push_ent = '{addr: cpu_req_addr, wdata: cpu_req_wdata, be: cpu_req_be};

  gpu_vram_wfifo #(
    .entry_t (wr_t),
    .DEPTH   (DEPTH)
  ) u_wfifo (
    .i_clock (clock),
    .i_reset (reset),
    .i_push  (w_push),
    .i_wdata (w_push_ent),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  // Strict priority: display, then drain posted writes, then CPU read.
  always_comb begin
    w_sel = OP_IDLE;
    if (disp_req)                                    w_sel = OP_DISP_RD;
    else if (!w_empty)                               w_sel = OP_CPU_WR;
    else if (cpu_req_valid && !cpu_req_we)           w_sel = OP_CPU_RD;
  end

  assign w_pop = (w_sel == OP_CPU_WR) && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mem_en       <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_mem_be       <= '0;
      r_s1           <= OP_IDLE;
      r_s2           <= OP_IDLE;
      r_disp_valid   <= 1'b0;
      r_disp_data    <= '0;
      r_cpu_rd_valid <= 1'b0;
      r_cpu_rd_data  <= '0;
    end else begin
      // Idle slots keep addr/data/be to avoid needless RAM-pin toggling.
      case (w_sel)
        OP_DISP_RD: begin
          r_mem_en   <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_addr <= disp_addr;
        end
        OP_CPU_WR: begin
          r_mem_en    <= 1'b1;
          r_mem_we    <= 1'b1;
          r_mem_addr  <= w_head.addr;
          r_mem_wdata <= w_head.wdata;
          r_mem_be    <= w_head.be;
        end
        OP_CPU_RD: begin
          r_mem_en   <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_addr <= cpu_req_addr;
        end
        default: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
        end
      endcase

      // Tag reaches S2 exactly when the RAM's read data is on mem_rdata.
      r_s1 <= w_sel;
      r_s2 <= r_s1;

      r_disp_valid   <= (r_s2 == OP_DISP_RD);
      r_cpu_rd_valid <= (r_s2 == OP_CPU_RD);
      if (is_rd(r_s2)) begin
        if (r_s2 == OP_DISP_RD) r_disp_data   <= mem_rdata;
        else                    r_cpu_rd_data <= mem_rdata;
      end
    end
  end

  assign mem_en       = r_mem_en;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign mem_be       = r_mem_be;
  assign disp_valid   = r_disp_valid;
  assign disp_data    = r_disp_data;
  assign cpu_rd_valid = r_cpu_rd_valid;
  assign cpu_rd_data  = r_cpu_rd_data;

endmodule

// File: tb/tb_gpu_vram_arbiter.sv
module tb_gpu_vram_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   disp_req;
  logic [ADDR_W-1:0]      disp_addr;
  logic                   disp_valid;
  logic [DATA_W-1:0]      disp_data;
  logic                   cpu_req_valid, cpu_req_we;
  logic [ADDR_W-1:0]      cpu_req_addr;
  logic [DATA_W-1:0]      cpu_req_wdata;
  logic [DATA_W/8-1:0]    cpu_req_be;
  logic                   cpu_req_ready;
  logic                   cpu_rd_valid;
  logic [DATA_W-1:0]      cpu_rd_data;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   mem_en, mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W/8-1:0]    mem_be;
  logic [DATA_W-1:0]      mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  gpu_vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_req_be(cpu_req_be), .cpu_req_ready(cpu_req_ready),
    .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data),
    .fifo_count(fifo_count),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  // Single-port RAM model: 1-cycle read, byte-enabled write.
  logic [DATA_W-1:0] ram [0:2047];
  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = '0;
    ram[11'h258] = 64'h0123_4567_89AB_CDEF;
    ram[11'h040] = 64'hD1D1_D1D1_D1D1_D1D1;
    ram[11'h041] = 64'hC2C2_C2C2_C2C2_C2C2;
  end
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < DATA_W/8; b++)
          if (mem_be[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_req_valid = 0; cpu_req_we = 0; cpu_req_addr = '0;
    cpu_req_wdata = '0; cpu_req_be = '0;
  endtask

  task automatic cpu_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cpu_req_valid = 1; cpu_req_we = 1; cpu_req_addr = a;
    cpu_req_wdata = d; cpu_req_be = 8'hFF;
  endtask

  task automatic cpu_rd(input logic [ADDR_W-1:0] a);
    cpu_req_valid = 1; cpu_req_we = 0; cpu_req_addr = a;
    cpu_req_wdata = '0; cpu_req_be = '0;
  endtask

  initial begin
    reset = 1; disp_req = 0; disp_addr = '0;
    cpu_wr(11'h7FF, 64'h1);

    // Reset state
    #1 chk("ready_in_reset", cpu_req_ready, 0);
    tick(); tick();
    chk("rst_mem_en",     mem_en, 0);
    chk("rst_mem_addr",   mem_addr, 0);
    chk("rst_mem_wdata",  mem_wdata, 0);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_disp_data",  disp_data, 0);
    chk("rst_cpu_rd_val", cpu_rd_valid, 0);
    chk("rst_fifo_count", fifo_count, 0);
    cpu_idle();
    reset = 0;
    tick();

    // Display-only read, 2-edge latency
    disp_req = 1; disp_addr = 11'h258;
    tick();
    chk("disp_mem_en",   mem_en, 1);
    chk("disp_mem_we",   mem_we, 0);
    chk("disp_mem_addr", mem_addr, 11'h258);
    chk("disp_vld_k",    disp_valid, 0);
    disp_req = 0;
    tick();
    chk("disp_vld_k1",   disp_valid, 0);
    chk("disp_idle_en",  mem_en, 0);
    chk("disp_idle_adr", mem_addr, 11'h258);
    tick();
    chk("disp_vld_k2",   disp_valid, 1);
    chk("disp_data",     disp_data, 64'h0123_4567_89AB_CDEF);
    tick();
    chk("disp_vld_k3",   disp_valid, 0);
    chk("disp_data_hold", disp_data, 64'h0123_4567_89AB_CDEF);

    // Display saturation holds off one posted write
    disp_req = 1; disp_addr = 11'h100;
    cpu_wr(11'h010, 64'hAAAA_AAAA_AAAA_AAAA);
    #1 chk("sat_ready", cpu_req_ready, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      cpu_idle();
      chk("sat_count", fifo_count, 1);
      chk("sat_no_we", mem_we, 0);
    end
    disp_req = 0;
    tick();
    chk("sat_wr_we",    mem_we, 1);
    chk("sat_wr_addr",  mem_addr, 11'h010);
    chk("sat_wr_data",  mem_wdata, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("sat_wr_count", fifo_count, 0);
    tick();
    chk("sat_ram", ram[11'h010], 64'hAAAA_AAAA_AAAA_AAAA);

    // FIFO full: 5 writes offered, 4 accepted
    disp_req = 1; disp_addr = 11'h101;
    for (int i = 0; i < 5; i++) begin
      cpu_wr(11'h020 + 11'(i), 64'(i + 1));
      #1 chk("full_ready", cpu_req_ready, (i < 4) ? 1 : 0);
      tick();
    end
    cpu_idle();
    chk("full_count", fifo_count, 4);
    disp_req = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_we",    mem_we, 1);
      chk("drain_addr",  mem_addr, 11'h020 + 11'(i));
      chk("drain_count", fifo_count, 3 - i);
    end
    tick(); tick();
    chk("drain_ram_last", ram[11'h023], 64'd4);
    chk("drain_ram_drop", ram[11'h024], 64'd0);

    // Read-after-write ordering
    cpu_wr(11'h030, 64'h5A5A_5A5A_5A5A_5A5A);
    #1 chk("raw_wr_ready", cpu_req_ready, 1);
    tick();
    chk("raw_count1", fifo_count, 1);
    cpu_rd(11'h030);
    #1 chk("raw_rd_held", cpu_req_ready, 0);
    tick();
    chk("raw_wr_issue", mem_we, 1);
    chk("raw_count0", fifo_count, 0);
    chk("raw_rd_ready", cpu_req_ready, 1);
    tick();
    cpu_idle();
    chk("raw_rd_en",   mem_en, 1);
    chk("raw_rd_we",   mem_we, 0);
    chk("raw_rd_addr", mem_addr, 11'h030);
    tick();
    chk("raw_vld_k1", cpu_rd_valid, 0);
    tick();
    chk("raw_vld_k2", cpu_rd_valid, 1);
    chk("raw_data",   cpu_rd_data, 64'h5A5A_5A5A_5A5A_5A5A);
    tick();
    chk("raw_vld_k3", cpu_rd_valid, 0);

    // Contention: display wins, CPU read one edge later
    disp_req = 1; disp_addr = 11'h040;
    cpu_rd(11'h041);
    #1 chk("cont_ready_k", cpu_req_ready, 0);
    tick();
    chk("cont_k_addr", mem_addr, 11'h040);
    disp_req = 0;
    #1 chk("cont_ready_k1", cpu_req_ready, 1);
    tick();
    cpu_idle();
    chk("cont_k1_addr", mem_addr, 11'h041);
    chk("cont_k1_en",   mem_en, 1);
    tick();
    chk("cont_disp_vld", disp_valid, 1);
    chk("cont_disp_dat", disp_data, 64'hD1D1_D1D1_D1D1_D1D1);
    chk("cont_cpu_vld0", cpu_rd_valid, 0);
    tick();
    chk("cont_cpu_vld",  cpu_rd_valid, 1);
    chk("cont_cpu_dat",  cpu_rd_data, 64'hC2C2_C2C2_C2C2_C2C2);
    chk("cont_disp_vld0", disp_valid, 0);

    // Reset mid-flight: reads in S1/S2, 3 writes queued
    disp_req = 1; disp_addr = 11'h102;
    for (int i = 0; i < 3; i++) begin
      cpu_wr(11'h050 + 11'(i), 64'hFFFF_0000_FFFF_0000);
      tick();
    end
    cpu_idle();
    chk("mf_count3", fifo_count, 3);
    disp_req = 0;
    reset = 1;
    tick();
    reset = 0;
    chk("mf_disp_vld", disp_valid, 0);
    chk("mf_count0",   fifo_count, 0);
    chk("mf_mem_en",   mem_en, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mf_post_dvld", disp_valid, 0);
      chk("mf_post_we",   mem_we, 0);
    end
    chk("mf_ram0", ram[11'h050], 64'd0);
    chk("mf_ram2", ram[11'h052], 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gpu_vram_arbiter.md
# gpu_vram_arbiter

Shares the single-port, 64-bit-wide video RAM between the character/pixel display fetch path and the CPU bus. The display path (which supplies `charData` words to the char/pixel renderer) gets absolute priority and a fixed 2-cycle read latency. CPU writes are posted through a small FIFO and drained into idle port slots. CPU reads are issued only once all posted writes have drained.

## Interface
Parameters:
- `ADDR_W`, 11, video RAM word address width (matches the renderer's `charAddress`)
- `DATA_W`, 64, video RAM word width
- `DEPTH`, 4, posted-write FIFO depth (power of two, ≥2)

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high
- `disp_req`  in  1  display fetch request; sampled every edge
- `disp_addr`  in  ADDR_W  display fetch address
- `disp_valid`  out  1  one-cycle pulse; `disp_data` is valid
- `disp_data`  out  DATA_W  fetched word
- `cpu_req_valid`  in  1  CPU request present
- `cpu_req_we`  in  1  1 = write, 0 = read
- `cpu_req_addr`  in  ADDR_W  CPU address
- `cpu_req_wdata`  in  DATA_W  write data
- `cpu_req_be`  in  DATA_W/8  byte enables for the write
- `cpu_req_ready`  out  1  request accepted on an edge where valid && ready
- `cpu_rd_valid`  out  1  one-cycle pulse; `cpu_rd_data` is valid
- `cpu_rd_data`  out  DATA_W  read data
- `fifo_count`  out  $clog2(DEPTH)+1  posted writes pending
- `mem_en`, `mem_we`  out  1  RAM port enable / write
- `mem_addr`  out  ADDR_W
- `mem_wdata`  out  DATA_W
- `mem_be`  out  DATA_W/8
- `mem_rdata`  in  DATA_W  RAM read data, valid the cycle after the RAM samples `mem_en` with `!mem_we`

## Operation
- Port slot selection happens at each edge, in strict priority order:
  1. `DISP_RD` if `disp_req`.
  2. Else `CPU_WR` if the FIFO is non-empty; the FIFO head is popped.
  3. Else `CPU_RD` if `cpu_req_valid && !cpu_req_we` and the FIFO is empty.
  4. Else `IDLE`.
- All `mem_*` outputs are registered and loaded with the selected op on that edge. For `IDLE`: `mem_en=0`, `mem_we=0`; address, data and byte enables hold their values.
- The op tag is carried through a 2-stage shift register (`S1`, `S2`) holding one of `IDLE`, `DISP_RD`, `CPU_WR`, `CPU_RD`. At the edge where `S2` holds a read tag, `mem_rdata` is registered into `disp_data` or `cpu_rd_data` and the matching valid is set for one cycle.
- `cpu_req_ready` is combinational:
  - Write: `!full`. Writes are always pushed into the FIFO, with no bypass.
  - Read: FIFO empty && `!disp_req`. This guarantees read-after-write ordering.
  - Forced to 0 while `reset` is high.
- FIFO push and pop on the same edge are legal whenever not full; `fifo_count` is unchanged. A push is never accepted while full, even if a pop occurs on that edge.
- Back-to-back requests pipeline freely: one new op per cycle, with no bubbles between reads.
- The display may request every cycle. The CPU then starves; no fairness mechanism is required.

## Timing
- Request sampled at edge k → `mem_*` driven during cycle k..k+1 → RAM samples at k+1 → `*_rd_valid` high for exactly the cycle following edge k+2. Read latency is fixed at 2 edges.
- Posted write accepted at edge k reaches `mem_we` at edge k+1 at the earliest, later if the display holds the port.
- `disp_data` and `cpu_rd_data` hold their last value when valid is low.
- Reset values: all `mem_*` = 0, `disp_valid` = 0, `disp_data` = 0, `cpu_rd_valid` = 0, `cpu_rd_data` = 0, `fifo_count` = 0, `S1` = `S2` = `IDLE`.
- Reset mid-operation: in-flight reads are dropped with no valid pulse, and the FIFO is flushed, so pending writes are lost. The first edge with `reset` low may already issue a `DISP_RD`.

## Structure
- Package `gpu_vram_pkg`:
  - op enum `{OP_IDLE, OP_DISP_RD, OP_CPU_WR, OP_CPU_RD}`
  - default `ADDR_W`/`DATA_W`
  - write-entry struct `{addr, wdata, be}`
- Sub-module `gpu_vram_wfifo`: synchronous FIFO of write entries with `push`/`pop`/`full`/`empty`/`count`, pointer wrap at `DEPTH`.
- The top level holds the priority mux, the `mem_*` registers, the 2-stage tag pipeline and the response registers.

## Test plan
- Display-only read: RAM[0x258] = 0x0123456789ABCDEF, `disp_req` at edge 10 with addr 0x258 → `mem_en` = 1 and `mem_addr` = 0x258 after edge 10; `disp_valid` = 1 with that data only after edge 12.
- Display saturation: `disp_req` held for 8 edges while the CPU writes 0x10 ← 0xAA.. (be 0xFF) → `fifo_count` = 1 throughout, `mem_we` = 0 during saturation, write issued on the first edge `disp_req` is low.
- FIFO full: display saturating, 5 CPU writes offered back-to-back → 4 accepted, `cpu_req_ready` = 0 on the 5th, `fifo_count` = 4; releasing the display drains one write per cycle.
- Ordering: write 0x10 ← 0x5A5A.., then read 0x10 → read held off (ready = 0) until `fifo_count` = 0; `cpu_rd_data` = 0x5A5A...
- Contention: `disp_req` and a CPU read at the same edge k → display issued at k, CPU read at k+1; `disp_valid` after k+2, `cpu_rd_valid` after k+3.
- Reset mid-flight: 2 reads in `S1`/`S2` and 3 writes queued, `reset` for 1 edge → no valid pulses, `fifo_count` = 0, `mem_en` = 0, and no writes ever reach the RAM.
